// File: rtl/sddac_adder_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sddac_adder_arbiter_pkg
// Constants and helpers shared by every user of the 48-bit dsp48a1_adder:
//   OPW      - operand / result width of the adder
//   OP_ADD   - P = C + (D:A:B)
//   OP_SUB   - P = C - (D:A:B)
//   OP_IDLE  - P = 0
// -----------------------------------------------------------------------------
package sddac_adder_arbiter_pkg;

   localparam int OPW = 48;

   typedef logic [OPW-1:0] operand_t;

   localparam logic [7:0] OP_ADD  = 8'h0F;
   localparam logic [7:0] OP_SUB  = 8'h8F;
   localparam logic [7:0] OP_IDLE = 8'h00;

   // Opmode for a granted request: subtract flag selects C - A over C + A.
   function automatic logic [7:0] op_sel(input logic sub);
      logic [7:0] op;
      if (sub) begin
         op = OP_SUB;
      end else begin
         op = OP_ADD;
      end
      return op;
   endfunction

endpackage

// File: rtl/sddac_adder_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Searches req_i starting at ptr_i
// and wrapping modulo NREQ; the first set request wins.
//   req_i  [NREQ] - request vector
//   ptr_i  [IDW]  - highest-priority index
//   gnt_o  [NREQ] - one-hot grant (all zero when no request)
//   idx_o  [IDW]  - encoded index of the grant
//   any_o  [1]    - a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter
   import sddac_adder_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   // Rotating priority search; explicit wrap keeps non-power-of-2 NREQ legal.
   always_comb begin
      int cand;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int k = 0; k < NREQ; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end else begin
            cand = cand;
         end
         if (!any_o && req_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand[IDW-1:0];
         end else begin
            any_o = any_o;
         end
      end
      if (any_o) begin
         gnt_o = ONE << idx_o;
      end else begin
         gnt_o = '0;
      end
   end

endmodule

// File: rtl/sddac_adder_arbiter.sv
// -----------------------------------------------------------------------------
// sddac_adder_arbiter
// Shares one dsp48a1_adder (P register only, 1-cycle latency) between NREQ
// requesters with round-robin arbitration, one operation per cycle.
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake
//   req_sub, req_a, req_c - per-requester op (C - A or C + A), 48-bit packed
//   add_opmode/dabin/cin  - registered issue stage driving the adder
//   add_pout              - adder P register output
//   res_valid/id/data     - result strobe, requester index and value
// Handshake at cycle t returns its result at cycle t+2.
// -----------------------------------------------------------------------------
module sddac_adder_arbiter
   import sddac_adder_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ-1:0]   req_sub,
   input  logic [NREQ*48-1:0] req_a,
   input  logic [NREQ*48-1:0] req_c,
   output logic [7:0]        add_opmode,
   output logic [47:0]       add_dabin,
   output logic [47:0]       add_cin,
   input  logic [47:0]       add_pout,
   output logic              res_valid,
   output logic [IDW-1:0]    res_id,
   output logic [47:0]       res_data
);

   logic [NREQ-1:0] arb_req_s;
   logic [NREQ-1:0] gnt_s;
   logic [IDW-1:0]  gnt_idx_s;
   logic            gnt_any_s;

   logic [IDW-1:0]  rr_ptr_q,   rr_ptr_d;
   logic [7:0]      opmode_q,   opmode_d;
   operand_t        dabin_q,    dabin_d;
   operand_t        cin_q,      cin_d;
   logic            s1_valid_q, s1_valid_d;
   logic [IDW-1:0]  s1_id_q,    s1_id_d;
   logic            s2_valid_q;
   logic [IDW-1:0]  s2_id_q;

   // Masking requests during reset keeps req_ready low without extra gating.
   assign arb_req_s = reset ? '0 : req_valid;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req_i (arb_req_s),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt_s),
      .idx_o (gnt_idx_s),
      .any_o (gnt_any_s)
   );

   assign req_ready  = gnt_s;
   assign add_opmode = opmode_q;
   assign add_dabin  = dabin_q;
   assign add_cin    = cin_q;
   assign res_valid  = s2_valid_q;
   assign res_id     = s2_id_q;
   assign res_data   = add_pout;

   // Next-state for pointer and issue stage; operands hold when idle to avoid toggling.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      opmode_d   = OP_IDLE;
      dabin_d    = dabin_q;
      cin_d      = cin_q;
      s1_valid_d = 1'b0;
      s1_id_d    = s1_id_q;
      if (gnt_any_s) begin
         if (gnt_idx_s == IDW'(NREQ - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_idx_s + IDW'(1);
         end
         opmode_d   = op_sel(req_sub[gnt_idx_s]);
         dabin_d    = req_a[int'(gnt_idx_s) * OPW +: OPW];
         cin_d      = req_c[int'(gnt_idx_s) * OPW +: OPW];
         s1_valid_d = 1'b1;
         s1_id_d    = gnt_idx_s;
      end else begin
         rr_ptr_d   = rr_ptr_q;
         s1_valid_d = 1'b0;
      end
   end

   // Pointer, issue and result-stage registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         opmode_q   <= OP_IDLE;
         dabin_q    <= '0;
         cin_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_id_q    <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         opmode_q   <= opmode_d;
         dabin_q    <= dabin_d;
         cin_q      <= cin_d;
         s1_valid_q <= s1_valid_d;
         s1_id_q    <= s1_id_d;
         s2_valid_q <= s1_valid_q;
         s2_id_q    <= s1_id_q;
      end
   end

endmodule
